fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the instruction memory (IM). It owns the program counter and drives the IM address. It tracks the IM's one-cycle registered read latency and buffers returned words in a 2-entry queue. It hands {pc, instruction} to decode over a valid/ready handshake and supports branch redirect, backpressure and halt-on-zero-word.

Parameters:
RESET_PC, 32'd0, first fetch address after start
PC_STEP, 32'd4, PC increment per sequential fetch
STOP_ON_ZERO, 1, 1 = a returned all-zero word (IM default) ends the program

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin fetching at RESET_PC from IDLE or HALT
im_pc  out  32  address to IM PC_in
im_instr  in  32  IM instruction output, valid the cycle after the address edge
redirect_valid  in  1  branch taken; redirect_pc is the new fetch address
redirect_pc  in  32  target; bits [1:0] forced to 0
out_valid  out  1  out_pc/out_instr valid
out_ready  in  1  decode accepts the word
out_pc  out  32  address of the delivered instruction
out_instr  out  32  delivered instruction
busy  out  1  state != IDLE and != HALT
halted  out  1  state == HALT

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue_pc=RESET_PC; inflight_valid=0; FIFO empty. Outputs: out_valid=0, out_pc=0, out_instr=0, busy=0, halted=0. im_pc=RESET_PC.
- im_pc = issue_pc register, combinational to the IM.
- States:
  - IDLE: on start, go to FETCH with issue_pc=RESET_PC.
  - FETCH: issue and capture per the rules below.
  - DRAIN: no issue; discard any in-flight word; go to HALT when FIFO empty.
  - HALT: halted=1; start behaves as in IDLE (FIFO/inflight already clear).
- Issue, FETCH only. issue_en = (occ + inflight_valid - pop) < 2, where pop = out_valid & out_ready.
  - On issue_en at an edge: inflight_valid<=1, inflight_pc<=issue_pc, issue_pc<=issue_pc+PC_STEP (32-bit wrap, no flag).
  - Otherwise inflight_valid<=0.
- Capture: in the cycle after an issue, im_instr belongs to inflight_pc.
  - Word nonzero, or STOP_ON_ZERO=0: push {inflight_pc, im_instr} to FIFO. The credit rule guarantees space.
  - Word zero and STOP_ON_ZERO=1: do not push; go to DRAIN. The issue in that same cycle still occurs and its word is discarded.
- Output: out_* driven from FIFO head; out_valid = !empty & !redirect_valid. Pop on out_valid & out_ready. Same-cycle push and pop on a 1-entry FIFO is legal.
- Latency: start sampled at edge E0 → first issue at E1 → out_valid=1, out_pc=RESET_PC after E2. Sustained throughput is 1 word/cycle with out_ready held high.
- Redirect (FETCH or DRAIN, redirect_valid=1):
  - FIFO flushed, inflight_valid<=0, issue_pc<=redirect_pc, state->FETCH.
  - No issue and no pop that cycle; out_valid masked to 0.
  - Issue of redirect_pc starts at the next edge.
  - Redirect in IDLE or HALT is ignored.
- Priority in one cycle: reset > redirect > start > capture/halt detection > issue.
- start while busy: ignored.
- Reset mid-operation: everything returns to reset values immediately. The in-flight word is dropped.

Decomposition:
- Shared package fetch_pkg: state enum {IDLE, FETCH, DRAIN, HALT}; constants FETCH_DEPTH=2, INSTR_W=32, ZERO_INSTR=32'd0.
- One sub-module fetch_buf: 2-entry synchronous FIFO of {pc, instr}.
  - Ports: push, pop, flush, occ, empty, head.
  - Flush has priority over push and pop.

Test Plan:
- Straight-line run: reset, start, out_ready=1 → out_pc 0, 4, 8 with out_instr 0xE3A00014, 0xE3A01A01, 0xE3A02103 on consecutive cycles; first valid 2 cycles after start edge.
- Halt: run to end → 18 words delivered (pc 0..68); the word from pc 72 (=0) is not delivered; halted=1, busy=0; im_pc stops advancing.
- Backpressure: out_ready=0 for 5 cycles after first valid → out_pc stays 0; occ reaches 2; no issue while full. Release → 4, 8 follow with no loss or duplication.
- Redirect: redirect_valid with redirect_pc=0x30 while pc 8 is pending → out_valid low that cycle; next delivered out_pc=0x30, out_instr=0x10810001, then 0x34. No stale 8/C appear.
- Redirect alignment and priority: redirect_pc=0x33 with same-cycle out_ready=1 and start=1 → fetch resumes at 0x30; no handshake in the redirect cycle.
- Reset mid-run: assert rst_n=0 with 2 words buffered → out_valid=0, im_pc=0 asynchronously. After release, start again → first word pc 0 again.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
    localparam int FETCH_DEPTH = 2;
    localparam int INSTR_W     = 32;
    localparam logic [INSTR_W-1:0] ZERO_INSTR = 32'd0;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} between the IM return path and decode.
// Flush wins over push and pop in the same cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   occ,
    output logic         empty,
    output fetch_entry_t head
);
    fetch_entry_t mem_q [FETCH_DEPTH];
    logic         rd_q, wr_q;
    logic [1:0]   occ_q;
    logic         do_push, do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (occ_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            occ_q <= 2'd0;
            for (int i = 0; i < FETCH_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (do_pop) rd_q <= ~rd_q;
            occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign occ   = occ_q;
    assign empty = (occ_q == 2'd0);
    assign head  = mem_q[rd_q];
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks the one-cycle IM read latency and
// hands {pc, instr} to decode, with redirect, backpressure and halt-on-zero.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter bit          STOP_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        busy,
    output logic        halted
);
    state_e       state_q;
    logic [31:0]  issue_pc_q, inflight_pc_q;
    logic         inflight_q, busy_q, halted_q;

    logic [1:0]   occ;
    logic         empty, pop, push, redir, capture, zero_word, issue_en;
    logic [2:0]   credit;
    fetch_entry_t head, din;

    assign redir     = redirect_valid & ((state_q == FETCH) | (state_q == DRAIN));
    assign out_valid = ~empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;

    assign zero_word = STOP_ON_ZERO && (im_instr == ZERO_INSTR);
    assign capture   = inflight_q && (state_q == FETCH) && !redir;
    assign push      = capture && !zero_word;

    // Count buffered, in-flight and leaving words so a returning word always has a slot.
    assign credit   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_en = (state_q == FETCH) && !redir && (credit < 3'd2);

    assign din.pc    = inflight_pc_q;
    assign din.instr = im_instr;

    fetch_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (din),
        .occ   (occ),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            issue_pc_q    <= RESET_PC;
            inflight_pc_q <= 32'd0;
            inflight_q    <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            inflight_q <= issue_en;
            if (issue_en) begin
                inflight_pc_q <= issue_pc_q;
                issue_pc_q    <= issue_pc_q + PC_STEP;
            end
            if (redir) begin
                issue_pc_q <= redirect_pc & ~32'd3;
                state_q    <= FETCH;
                busy_q     <= 1'b1;
                halted_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, HALT: if (start) begin
                        state_q    <= FETCH;
                        issue_pc_q <= RESET_PC;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                    FETCH: if (capture && zero_word) state_q <= DRAIN;
                    DRAIN: if (empty) begin
                        state_q  <= HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign im_pc     = issue_pc_q;
    assign out_pc    = empty ? 32'd0 : head.pc;
    assign out_instr = empty ? 32'd0 : head.instr;
    assign busy      = busy_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: registered-read IM model plus an in-order
// scoreboard of expected {pc, instr} deliveries.
module tb_fetch_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = 32'd0, im_instr = 32'd0;
    logic [31:0] im_pc, out_pc, out_instr;
    logic        out_valid, busy, halted;

    logic [31:0] mem [64];
    logic [63:0] exp_q [$];
    logic [63:0] sb_e;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .im_pc          (im_pc),
        .im_instr       (im_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .busy           (busy),
        .halted         (halted)
    );

    // IM: one-cycle registered read
    always @(posedge clk) im_instr <= mem[im_pc[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: every handshake must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_chk++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL sb_extra: observed pc %h expected no delivery", out_pc);
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                check("sb_pc", out_pc, sb_e[63:32]);
                check("sb_instr", out_instr, sb_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({32'(i * 4), mem[i]});
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i < 18) ? (32'hA000_0000 | 32'(i)) : 32'd0;
        mem[0]  = 32'hE3A0_0014;
        mem[1]  = 32'hE3A0_1A01;
        mem[2]  = 32'hE3A0_2103;
        mem[12] = 32'h1081_0001;

        // Reset state
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_im_pc", im_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Straight-line run to halt
        out_ready = 1'b1;
        push_exp(0, 17);
        pulse_start();
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_lat0", {31'd0, out_valid}, 32'd0);
        tick();
        check("run_lat1", {31'd0, out_valid}, 32'd0);
        check("run_im_pc1", im_pc, 32'd4);
        tick();
        check("run_first_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("run_v1", {31'd0, out_valid}, 32'd1);
        check("run_pc1", out_pc, 32'd4);
        tick();
        check("run_v2", {31'd0, out_valid}, 32'd1);
        check("run_pc2", out_pc, 32'd8);
        wait_halt("run");
        check("run_im_pc_end", im_pc, 32'h50);
        repeat (3) tick();
        check("run_im_pc_hold", im_pc, 32'h50);
        check("run_valid_end", {31'd0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        push_exp(0, 17);
        pulse_start();
        tick();
        tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_pc", out_pc, 32'd0);
        end
        check("bp_occ", {30'd0, dut.occ}, 32'd2);
        check("bp_im_pc", im_pc, 32'd8);
        out_ready = 1'b1;
        wait_halt("bp");

        // Redirect while pc 8 is at the head
        push_exp(0, 1);
        push_exp(12, 17);
        pulse_start();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        #1;
        check("redir_mask", {31'd0, out_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("redir_im_pc", im_pc, 32'h30);
        wait_halt("redir");

        // Misaligned redirect with competing start and ready
        push_exp(12, 17);
        pulse_start();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h33;
        start          = 1'b1;
        #1;
        check("align_mask", {31'd0, out_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        start          = 1'b0;
        check("align_im_pc", im_pc, 32'h30);
        check("align_busy", {31'd0, busy}, 32'd1);
        wait_halt("align");

        // Asynchronous reset with two words buffered
        out_ready = 1'b0;
        pulse_start();
        repeat (5) tick();
        check("mid_occ", {30'd0, dut.occ}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_im_pc", im_pc, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_occ", {30'd0, dut.occ}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        push_exp(0, 17);
        pulse_start();
        tick();
        tick();
        check("mid_first_valid", {31'd0, out_valid}, 32'd1);
        check("mid_first_pc", out_pc, 32'd0);
        wait_halt("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
